// File: rtl/pipe_sched.sv
// pipe_sched: round-robin issue of per-channel samples into one shared fixed-latency stage,
// with channel tags re-attached to the stage results. Optional sticky tag check: PIPE_SCHED_ERR_EN.
module pipe_sched #(
  parameter int NCH     = 4,
  parameter int CHW     = 2,
  parameter int LATENCY = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    req,
  input  logic [32*NCH-1:0] req_sample,
  output logic [NCH-1:0]    ack,
  output logic [NCH-1:0]    overrun,
  output logic              stage_en,
  output logic [31:0]       stage_sample,
  input  logic              stage_ready,
  input  logic              stage_valid,
  input  logic [31:0]       stage_result,
  output logic              out_valid,
  output logic [CHW-1:0]    out_ch,
  output logic [31:0]       out_sample,
  output logic              err
);

  logic [NCH-1:0] pend_reg, pend_next;
  logic [NCH-1:0] overrun_reg, overrun_next;
  logic [NCH-1:0] ack_reg;
  logic [31:0]    hold_reg [NCH];
  logic [CHW-1:0] ptr_reg;
  logic           stage_en_reg;
  logic [CHW-1:0] en_ch_reg;
  logic [31:0]    stage_sample_reg;
  logic [LATENCY-1:0] tag_v_reg;
  logic [CHW-1:0] tag_ch_reg [LATENCY];
  logic           out_valid_reg;
  logic [CHW-1:0] out_ch_reg;
  logic [31:0]    out_sample_reg;

  logic           grant_v;
  logic [CHW-1:0] grant_ch;
  logic [NCH-1:0] grant_oh;

  // Two passes give "first pending at or above ptr, else first pending below ptr".
  always_comb begin
    grant_v  = 1'b0;
    grant_ch = '0;
    if (stage_ready) begin
      for (int j = 0; j < NCH; j++) begin
        if (!grant_v && pend_reg[j] && (j >= int'(ptr_reg))) begin
          grant_v  = 1'b1;
          grant_ch = CHW'(j);
        end
      end
      for (int j = 0; j < NCH; j++) begin
        if (!grant_v && pend_reg[j] && (j < int'(ptr_reg))) begin
          grant_v  = 1'b1;
          grant_ch = CHW'(j);
        end
      end
    end
  end

  // A new request always wins over the grant clear, so pend stays set on a same-edge grant.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
    assign grant_oh[gi]     = grant_v && (grant_ch == CHW'(gi));
    assign pend_next[gi]    = req[gi] | (pend_reg[gi] & ~grant_oh[gi]);
    assign overrun_next[gi] = overrun_reg[gi] | (req[gi] & pend_reg[gi] & ~grant_oh[gi]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_reg         <= '0;
      overrun_reg      <= '0;
      ack_reg          <= '0;
      ptr_reg          <= '0;
      stage_en_reg     <= 1'b0;
      en_ch_reg        <= '0;
      stage_sample_reg <= '0;
      for (int c = 0; c < NCH; c++) hold_reg[c] <= '0;
    end else begin
      pend_reg     <= pend_next;
      overrun_reg  <= overrun_next;
      ack_reg      <= grant_oh;
      stage_en_reg <= grant_v;
      for (int c = 0; c < NCH; c++)
        if (req[c]) hold_reg[c] <= req_sample[32*c +: 32];
      if (grant_v) begin
        en_ch_reg        <= grant_ch;
        stage_sample_reg <= hold_reg[grant_ch];
        ptr_reg          <= (grant_ch == CHW'(NCH-1)) ? '0 : grant_ch + 1'b1;
      end
    end
  end

  // Tag line is fed from the registered issue so its tail lines up with stage_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_v_reg <= '0;
      for (int i = 0; i < LATENCY; i++) tag_ch_reg[i] <= '0;
    end else begin
      tag_v_reg[0]  <= stage_en_reg;
      tag_ch_reg[0] <= en_ch_reg;
      for (int i = 1; i < LATENCY; i++) begin
        tag_v_reg[i]  <= tag_v_reg[i-1];
        tag_ch_reg[i] <= tag_ch_reg[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg  <= 1'b0;
      out_ch_reg     <= '0;
      out_sample_reg <= '0;
    end else begin
      out_valid_reg <= stage_valid & tag_v_reg[LATENCY-1];
      if (stage_valid && tag_v_reg[LATENCY-1]) begin
        out_ch_reg     <= tag_ch_reg[LATENCY-1];
        out_sample_reg <= stage_result;
      end
    end
  end

`ifdef PIPE_SCHED_ERR_EN
  logic err_reg;
  always_ff @(posedge clk) begin
    if (rst) err_reg <= 1'b0;
    else if (stage_valid != tag_v_reg[LATENCY-1]) err_reg <= 1'b1;
  end
  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

  assign ack          = ack_reg;
  assign overrun      = overrun_reg;
  assign stage_en     = stage_en_reg;
  assign stage_sample = stage_sample_reg;
  assign out_valid    = out_valid_reg;
  assign out_ch       = out_ch_reg;
  assign out_sample   = out_sample_reg;

endmodule

// File: tb/tb_pipe_sched.sv
// Directed bench for pipe_sched: the shared stage is a 9-cycle pass-through delay that
// ignores rst, so results in flight across a reset arrive untagged.
module tb_pipe_sched;
  localparam int NCH = 4;
  localparam int CHW = 2;
  localparam int LAT = 9;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH-1:0]    req;
  logic [32*NCH-1:0] req_sample;
  logic [NCH-1:0]    ack;
  logic [NCH-1:0]    overrun;
  logic              stage_en;
  logic [31:0]       stage_sample;
  logic              stage_ready;
  logic              stage_valid;
  logic [31:0]       stage_result;
  logic              out_valid;
  logic [CHW-1:0]    out_ch;
  logic [31:0]       out_sample;
  logic              err;

  int n_checks = 0;
  int n_err    = 0;
  logic [LAT-1:0] dv = '0;
  logic [31:0]    ds [LAT];
  logic           seen;
  logic           exp_err;

  pipe_sched #(.NCH(NCH), .CHW(CHW), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .req(req), .req_sample(req_sample),
    .ack(ack), .overrun(overrun), .stage_en(stage_en), .stage_sample(stage_sample),
    .stage_ready(stage_ready), .stage_valid(stage_valid), .stage_result(stage_result),
    .out_valid(out_valid), .out_ch(out_ch), .out_sample(out_sample), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    dv    <= {dv[LAT-2:0], stage_en};
    ds[0] <= stage_sample;
    for (int i = 1; i < LAT; i++) ds[i] <= ds[i-1];
  end
  assign stage_valid  = dv[LAT-1];
  assign stage_result = ds[LAT-1];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = '0; req_sample = '0; stage_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    check("rst_ack", 32'(ack), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_stage_en", 32'(stage_en), 0);
    check("rst_stage_sample", stage_sample, 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_ch", 32'(out_ch), 0);
    check("rst_out_sample", out_sample, 0);
    check("rst_err", 32'(err), 0);

    // single channel, end-to-end latency 12
    req[2] = 1'b1; req_sample[95:64] = 32'h0000_1234;
    step(); req = '0;
    check("t1_ack_e0", 32'(ack), 0);
    check("t1_en_e0", 32'(stage_en), 0);
    step();
    check("t1_ack_e1", 32'(ack), 32'h4);
    check("t1_en_e1", 32'(stage_en), 1);
    check("t1_sample_e1", stage_sample, 32'h0000_1234);
    for (int i = 0; i < 9; i++) step();
    check("t1_out_valid_e10", 32'(out_valid), 0);
    step();
    check("t1_out_valid_e11", 32'(out_valid), 1);
    check("t1_out_ch", 32'(out_ch), 2);
    check("t1_out_sample", out_sample, 32'h0000_1234);
    step();
    check("t1_out_valid_e12", 32'(out_valid), 0);

    // all channels at once drain in order
    do_reset();
    req = 4'hF;
    for (int k = 0; k < NCH; k++) req_sample[32*k +: 32] = 32'hA0 + 32'(k);
    step(); req = '0;
    for (int k = 0; k < NCH; k++) begin
      step();
      check($sformatf("t2_ack_%0d", k), 32'(ack), 32'(1 << k));
      check($sformatf("t2_sample_%0d", k), stage_sample, 32'hA0 + 32'(k));
    end
    for (int i = 0; i < 6; i++) step();
    for (int k = 0; k < NCH; k++) begin
      step();
      check($sformatf("t2_out_valid_%0d", k), 32'(out_valid), 1);
      check($sformatf("t2_out_ch_%0d", k), 32'(out_ch), 32'(k));
      check($sformatf("t2_out_sample_%0d", k), out_sample, 32'hA0 + 32'(k));
    end
    check("t2_overrun", 32'(overrun), 0);

    // fairness: ptr=1 with ch0 and ch3 pending
    do_reset();
    req[0] = 1'b1; req_sample[31:0] = 32'h10;
    step(); req = '0;
    step();
    check("t3_first_ack", 32'(ack), 1);
    stage_ready = 1'b0;
    req = 4'b1001; req_sample[31:0] = 32'h20; req_sample[127:96] = 32'h23;
    step(); req = '0;
    step();
    check("t3_no_en", 32'(stage_en), 0);
    stage_ready = 1'b1;
    step();
    check("t3_ack_ch3", 32'(ack), 32'h8);
    check("t3_sample_ch3", stage_sample, 32'h23);
    step();
    check("t3_ack_ch0", 32'(ack), 32'h1);
    check("t3_sample_ch0", stage_sample, 32'h20);
    check("t3_overrun", 32'(overrun), 0);

    // stall for 5 cycles with ch1 pending
    stage_ready = 1'b0;
    req[1] = 1'b1; req_sample[63:32] = 32'h55;
    step(); req = '0;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("t4_stall_en_%0d", i), 32'(stage_en), 0);
    end
    stage_ready = 1'b1;
    step();
    check("t4_en", 32'(stage_en), 1);
    check("t4_ack", 32'(ack), 32'h2);
    check("t4_sample", stage_sample, 32'h55);

    // overrun on ch0 while stalled
    stage_ready = 1'b0;
    req[0] = 1'b1; req_sample[31:0] = 32'h31;
    step();
    req_sample[31:0] = 32'h32;
    step(); req = '0;
    check("t5_overrun_set", 32'(overrun), 1);
    stage_ready = 1'b1;
    step();
    check("t5_ack", 32'(ack), 1);
    check("t5_sample", stage_sample, 32'h32);
    step();
    check("t5_issued_once", 32'(stage_en), 0);
    check("t5_overrun_sticky", 32'(overrun), 1);
    for (int i = 0; i < 12; i++) step();

    // reset with three issues in flight; stage keeps running
    do_reset();
    check("t6_err_before", 32'(err), 0);
    req = 4'b0111;
    for (int k = 0; k < 3; k++) req_sample[32*k +: 32] = 32'hC0 + 32'(k);
    step(); req = '0;
    step(); step(); step();
    check("t6_third_issue", 32'(stage_en), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_en_cleared", 32'(stage_en), 0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    check("t6_stale_dropped", 32'(seen), 0);
`ifdef PIPE_SCHED_ERR_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    check("t6_err", 32'(err), 32'(exp_err));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
